// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchroniser and stability-counter debouncer with rise/fall pulses.
// Optional sticky change flags are built only when SW_EVENT_LATCH_EN is defined.
module switch_debouncer #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_any_change,
    input  logic [N_SW-1:0] evt_clr,
    output logic [N_SW-1:0] evt_sticky
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0] sync1_q, sync2_q;
    logic [N_SW-1:0] stable_q, stable_d;
    logic [N_SW-1:0] rise_q, rise_d;
    logic [N_SW-1:0] fall_q, fall_d;
    logic            any_q, any_d;
    logic [N_SW-1:0] differ, accept;

    assign differ = sync2_q ^ stable_q;

    // Each bit owns its counter; it only runs while the synchronised input disagrees with the accepted level.
    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign accept[gi] = differ[gi] && (cnt_q == CNT_LAST);

            always_comb begin
                cnt_d = '0;
                if (differ[gi] && !accept[gi]) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        stable_d = stable_q ^ accept;
        rise_d   = accept & sync2_q;
        fall_d   = accept & ~sync2_q;
        any_d    = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= any_d;
        end
    end

    assign sw_stable     = stable_q;
    assign sw_rise       = rise_q;
    assign sw_fall       = fall_q;
    assign sw_any_change = any_q;

`ifdef SW_EVENT_LATCH_EN
    logic [N_SW-1:0] sticky_q, sticky_d;

    // Setting from the accept event makes the flag rise together with the pulse, and lets set beat clear.
    always_comb begin
        sticky_d = (sticky_q & ~evt_clr) | rise_d | fall_d;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign evt_sticky = sticky_q;
`else
    logic unused_evt_clr;
    assign unused_evt_clr = ^evt_clr;
    assign evt_sticky     = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=4, N_SW=10.
// Sticky-flag checks follow SW_EVENT_LATCH_EN the same way the design does.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       nreset;
    logic [9:0] sw_raw;
    logic [9:0] sw_stable, sw_rise, sw_fall;
    logic       sw_any_change;
    logic [9:0] evt_clr;
    logic [9:0] evt_sticky;

    int n_vec = 0;
    int n_err = 0;

    switch_debouncer #(
        .N_SW(10),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_any_change(sw_any_change),
        .evt_clr(evt_clr),
        .evt_sticky(evt_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [9:0] st, input logic [9:0] ri,
                           input logic [9:0] fa, input logic an);
        chk({tag, ".stable"}, {22'd0, sw_stable}, {22'd0, st});
        chk({tag, ".rise"},   {22'd0, sw_rise},   {22'd0, ri});
        chk({tag, ".fall"},   {22'd0, sw_fall},   {22'd0, fa});
        chk({tag, ".any"},    {31'd0, sw_any_change}, {31'd0, an});
`ifndef SW_EVENT_LATCH_EN
        chk({tag, ".sticky_off"}, {22'd0, evt_sticky}, 32'd0);
`endif
    endtask

    initial begin
        nreset  = 1'b0;
        sw_raw  = 10'h3FF;
`ifdef SW_EVENT_LATCH_EN
        evt_clr = 10'h000;
`else
        evt_clr = 10'h3FF;
`endif

        // Reset with switches held high
        tick(3);
        chk_out("in_reset", 10'h000, 10'h000, 10'h000, 1'b0);
        nreset = 1'b1;
        #1;
        chk_out("release", 10'h000, 10'h000, 10'h000, 1'b0);
        tick(5);
        chk_out("rst_e5", 10'h000, 10'h000, 10'h000, 1'b0);
        tick(1);
        chk_out("rst_e6", 10'h3FF, 10'h3FF, 10'h000, 1'b1);
        tick(1);
        chk_out("rst_e7", 10'h3FF, 10'h000, 10'h000, 1'b0);

        // All switches drop together
        sw_raw = 10'h000;
        tick(6);
        chk_out("alldown_e6", 10'h000, 10'h000, 10'h3FF, 1'b1);
        tick(1);
        chk_out("alldown_e7", 10'h000, 10'h000, 10'h000, 1'b0);

        // Clean rising edge on bit 0
        sw_raw = 10'h001;
        tick(5);
        chk_out("clean_e5", 10'h000, 10'h000, 10'h000, 1'b0);
        tick(1);
        chk_out("clean_e6", 10'h001, 10'h001, 10'h000, 1'b1);
        tick(1);
        chk_out("clean_e7", 10'h001, 10'h000, 10'h000, 1'b0);

        // Bounce on bit 3: 1,0,1,0 one cycle each, then hold 1
        for (int i = 0; i < 4; i++) begin
            sw_raw[3] = (i % 2 == 0);
            tick(1);
            chk_out("bounce", 10'h001, 10'h000, 10'h000, 1'b0);
        end
        sw_raw[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_out("bounce_hold", 10'h001, 10'h000, 10'h000, 1'b0);
        end
        tick(1);
        chk_out("bounce_e6", 10'h009, 10'h008, 10'h000, 1'b1);
        tick(1);
        chk_out("bounce_e7", 10'h009, 10'h000, 10'h000, 1'b0);

        // Bring bit 5 to a stable 1
        sw_raw = 10'h029;
        tick(6);
        chk_out("b5_up", 10'h029, 10'h020, 10'h000, 1'b1);
        tick(1);

        // Bit 5 falls while bit 2 rises on the same edge
        sw_raw = 10'h00D;
        tick(5);
        chk_out("indep_e5", 10'h029, 10'h000, 10'h000, 1'b0);
        tick(1);
        chk_out("indep_e6", 10'h00D, 10'h004, 10'h020, 1'b1);
        tick(1);
        chk_out("indep_e7", 10'h00D, 10'h000, 10'h000, 1'b0);

        // Asynchronous reset in the middle of bit 7's count
        sw_raw = 10'h08D;
        tick(3);
        chk_out("mid_e3", 10'h00D, 10'h000, 10'h000, 1'b0);
        #3;
        nreset = 1'b0;
        #1;
        chk_out("async_clr", 10'h000, 10'h000, 10'h000, 1'b0);
        tick(2);
        chk_out("async_hold", 10'h000, 10'h000, 10'h000, 1'b0);
        nreset = 1'b1;
        tick(5);
        chk_out("rel_e5", 10'h000, 10'h000, 10'h000, 1'b0);
        tick(1);
        chk_out("rel_e6", 10'h08D, 10'h08D, 10'h000, 1'b1);
        tick(1);
        chk_out("rel_e7", 10'h08D, 10'h000, 10'h000, 1'b0);

`ifdef SW_EVENT_LATCH_EN
        chk("sticky_after_rel", {22'd0, evt_sticky}, 32'h08D);
        evt_clr = 10'h3FF;
        tick(1);
        evt_clr = 10'h000;
        chk("sticky_cleared", {22'd0, evt_sticky}, 32'h000);

        sw_raw = 10'h08F;
        tick(6);
        chk("sticky_rise_pulse", {22'd0, sw_rise}, 32'h002);
        chk("sticky_c1", {22'd0, evt_sticky}, 32'h002);
        tick(1);
        chk("sticky_c2", {22'd0, evt_sticky}, 32'h002);
        evt_clr = 10'h002;
        tick(1);
        evt_clr = 10'h000;
        chk("sticky_clr", {22'd0, evt_sticky}, 32'h000);

        sw_raw = 10'h08D;
        tick(5);
        chk("sticky_pre", {22'd0, evt_sticky}, 32'h000);
        evt_clr = 10'h002;
        tick(1);
        evt_clr = 10'h000;
        chk("setclr_fall", {22'd0, sw_fall}, 32'h002);
        chk("set_wins", {22'd0, evt_sticky}, 32'h002);
        tick(1);
        chk("set_held", {22'd0, evt_sticky}, 32'h002);
`else
        sw_raw = 10'h08F;
        tick(6);
        chk_out("nolatch_rise", 10'h08F, 10'h002, 10'h000, 1'b1);
        evt_clr = 10'h000;
        tick(1);
        chk_out("nolatch_after", 10'h08F, 10'h000, 10'h000, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
